alu_word_sequencer: RTL and testbench

//  Initiator side of the ALU interface: drives op1/op2/opcode/carry/oe into the combinational
//  ALU and captures out/flags. Runs one multi-precision operation of p_words ALU words,
//  one word per cycle, chaining carry/borrow and shift bits between words.

---
 rtl/alu_word_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_word_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// ---------------------------------------------------------------------------
// alu_word_sequencer
//
// Initiator for a single-word combinational ALU. One request describes a wide
// (p_words * p_data_width) operation. The sequencer feeds the ALU one word per
// cycle and chains carry/borrow or shifted-out bits between words. It then
// assembles the wide result and composite flags and returns them over a
// valid/ready response port.
//
// Ports
//   i_w_clk, i_w_rst_n         clock, synchronous active-low reset
//   i_w_req_*  / o_w_req_ready request: opcode, wide operands, carry-in
//   o_w_rsp_*  / i_w_rsp_ready response: wide result, flags {P,S,Z,O,C}
//   o_w_alu_*                  registered word-level drive into the ALU
//   i_w_alu_out, i_w_alu_flags ALU result for the word driven this cycle
// ---------------------------------------------------------------------------
module alu_word_sequencer #(
    parameter int p_data_width  = 16,
    parameter int p_flags_width = 5,
    parameter int p_words       = 2
) (
    input  logic                              i_w_clk,
    input  logic                              i_w_rst_n,
    input  logic                              i_w_req_valid,
    output logic                              o_w_req_ready,
    input  logic [3:0]                        i_w_req_opcode,
    input  logic [p_words*p_data_width-1:0]   i_w_req_op1,
    input  logic [p_words*p_data_width-1:0]   i_w_req_op2,
    input  logic                              i_w_req_carry,
    output logic                              o_w_rsp_valid,
    input  logic                              i_w_rsp_ready,
    output logic [p_words*p_data_width-1:0]   o_w_rsp_result,
    output logic [p_flags_width-1:0]          o_w_rsp_flags,
    output logic [p_data_width-1:0]           o_w_alu_op1,
    output logic [p_data_width-1:0]           o_w_alu_op2,
    output logic [3:0]                        o_w_alu_opcode,
    output logic                              o_w_alu_carry,
    output logic                              o_w_alu_oe,
    input  logic [p_data_width-1:0]           i_w_alu_out,
    input  logic [p_flags_width-1:0]          i_w_alu_flags
);

    localparam int WW = p_words * p_data_width;
    localparam int SW = (p_words > 1) ? $clog2(p_words) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(p_words - 1);

    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;

    localparam int FLAG_C = 0;
    localparam int FLAG_O = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [WW-1:0]     op1_q;
    logic [WW-1:0]     op2_q;
    logic [3:0]        opcode_q;
    logic [SW-1:0]     step_q;
    logic              prev_c_q;
    logic              flag_c_q;
    logic              flag_o_q;
    logic [WW-1:0]     result_q;

    logic [3:0]            src_op;
    logic [WW-1:0]         src_op1;
    logic [WW-1:0]         src_op2;
    logic [SW-1:0]         nxt_step;
    logic [SW-1:0]         nxt_idx;
    logic                  nxt_carry_in;
    logic [p_data_width-1:0] nxt_alu_op1;
    logic [p_data_width-1:0] nxt_alu_op2;
    logic [3:0]            nxt_alu_opcode;
    logic                  nxt_alu_carry;
    logic [SW-1:0]         cur_idx;
    logic [p_data_width-1:0] cap_word;
    logic [p_flags_width-1:0] comp_flags;

    // P, S and Z of individual words do not contribute to the wide flags.
    logic unused_alu_flags;
    assign unused_alu_flags = ^i_w_alu_flags[p_flags_width-1:2];

    // Right shifts walk from the most significant word down so the bit
    // shifted out of a word can be injected into the msb of the next one.
    function automatic logic is_shift_right(input logic [3:0] op);
        return (op == OP_SHR) || (op == OP_SAR);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return op <= 4'd2;
    endfunction

    function automatic logic [SW-1:0] word_idx(input logic [3:0] op,
                                               input logic [SW-1:0] step);
        return is_shift_right(op) ? (LAST_STEP - step) : step;
    endfunction

    // The ALU drive for the next step is prepared one cycle ahead. From IDLE it
    // comes straight from the request; in RUN it comes from the stored operands,
    // and the carry chains from the ALU carry-out of the word now being processed.
    always_comb begin
        src_op       = (state == ST_IDLE) ? i_w_req_opcode : opcode_q;
        src_op1      = (state == ST_IDLE) ? i_w_req_op1    : op1_q;
        src_op2      = (state == ST_IDLE) ? i_w_req_op2    : op2_q;
        nxt_step     = (state == ST_IDLE) ? '0 : step_q + 1'b1;
        nxt_carry_in = (state == ST_IDLE) ? i_w_req_carry : i_w_alu_flags[FLAG_C];
        nxt_idx      = word_idx(src_op, nxt_step);
        nxt_alu_op1  = src_op1[nxt_idx*p_data_width +: p_data_width];
        nxt_alu_op2  = is_shift(src_op) ? '0 : src_op2[nxt_idx*p_data_width +: p_data_width];
        // Only the most significant word shifts arithmetically; lower words
        // take the sign-independent shift plus the injected bit.
        nxt_alu_opcode = (src_op == OP_SAR && nxt_idx != LAST_STEP) ? OP_SHR : src_op;
        nxt_alu_carry  = is_arith(src_op) ? nxt_carry_in : 1'b0;
    end

    // Capture path: patch the ALU word with the bit that crossed the word
    // boundary from the previous step. prev_c_q is cleared on accept, so the
    // first word of SHL receives a zero.
    always_comb begin
        cur_idx  = word_idx(opcode_q, step_q);
        cap_word = i_w_alu_out;
        if (opcode_q == OP_SHL) begin
            cap_word[0] = prev_c_q;
        end else if (is_shift_right(opcode_q) && cur_idx != LAST_STEP) begin
            cap_word[p_data_width-1] = prev_c_q;
        end
        comp_flags = {~^result_q[p_data_width-1:0],
                      result_q[WW-1],
                      (result_q == '0),
                      flag_o_q,
                      flag_c_q};
    end

    // Single FSM. All interface outputs are registered here. DONE spends one
    // cycle forming the composite flags before raising rsp_valid.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            state          <= ST_IDLE;
            op1_q          <= '0;
            op2_q          <= '0;
            opcode_q       <= '0;
            step_q         <= '0;
            prev_c_q       <= 1'b0;
            flag_c_q       <= 1'b0;
            flag_o_q       <= 1'b0;
            result_q       <= '0;
            o_w_req_ready  <= 1'b1;
            o_w_rsp_valid  <= 1'b0;
            o_w_rsp_result <= '0;
            o_w_rsp_flags  <= '0;
            o_w_alu_op1    <= '0;
            o_w_alu_op2    <= '0;
            o_w_alu_opcode <= '0;
            o_w_alu_carry  <= 1'b0;
            o_w_alu_oe     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_w_req_valid && o_w_req_ready) begin
                        op1_q          <= i_w_req_op1;
                        op2_q          <= i_w_req_op2;
                        opcode_q       <= i_w_req_opcode;
                        step_q         <= '0;
                        prev_c_q       <= 1'b0;
                        o_w_alu_op1    <= nxt_alu_op1;
                        o_w_alu_op2    <= nxt_alu_op2;
                        o_w_alu_opcode <= nxt_alu_opcode;
                        o_w_alu_carry  <= nxt_alu_carry;
                        o_w_alu_oe     <= 1'b1;
                        o_w_req_ready  <= 1'b0;
                        state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q[cur_idx*p_data_width +: p_data_width] <= cap_word;
                    prev_c_q <= i_w_alu_flags[FLAG_C];
                    if (cur_idx == LAST_STEP) begin
                        flag_c_q <= i_w_alu_flags[FLAG_C];
                        flag_o_q <= i_w_alu_flags[FLAG_O];
                    end
                    // Right shifts report the bit that finally fell off word 0.
                    if (is_shift_right(opcode_q) && step_q == LAST_STEP) begin
                        flag_c_q <= i_w_alu_flags[FLAG_C];
                    end
                    if (step_q == LAST_STEP) begin
                        o_w_alu_op1    <= '0;
                        o_w_alu_op2    <= '0;
                        o_w_alu_opcode <= '0;
                        o_w_alu_carry  <= 1'b0;
                        o_w_alu_oe     <= 1'b0;
                        state          <= ST_DONE;
                    end else begin
                        step_q         <= nxt_step;
                        o_w_alu_op1    <= nxt_alu_op1;
                        o_w_alu_op2    <= nxt_alu_op2;
                        o_w_alu_opcode <= nxt_alu_opcode;
                        o_w_alu_carry  <= nxt_alu_carry;
                    end
                end
                ST_DONE: begin
                    if (!o_w_rsp_valid) begin
                        o_w_rsp_valid  <= 1'b1;
                        o_w_rsp_result <= result_q;
                        o_w_rsp_flags  <= comp_flags;
                    end else if (i_w_rsp_ready) begin
                        o_w_rsp_valid <= 1'b0;
                        o_w_req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_word_sequencer
//
// Directed bench for alu_word_sequencer with 16-bit words and two words per
// operation. A behavioural 16-bit ALU closes the loop around the sequencer.
// Expected wide results and flags are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_word_sequencer;

    localparam int DW = 16;
    localparam int FW = 5;
    localparam int NW = 2;
    localparam int WW = DW * NW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_opcode;
    logic [WW-1:0]   req_op1;
    logic [WW-1:0]   req_op2;
    logic            req_carry;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [WW-1:0]   rsp_result;
    logic [FW-1:0]   rsp_flags;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [3:0]      alu_opcode;
    logic            alu_carry;
    logic            alu_oe;
    logic [DW-1:0]   alu_out;
    logic [FW-1:0]   alu_flags;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [3:0]    step_opcode [NW];
    logic          step_carry  [NW];
    logic          step_cout   [NW];
    logic          step_oe     [NW];
    logic [DW-1:0] step_op1    [NW];

    always #5 clk = ~clk;

    alu_word_sequencer #(
        .p_data_width (DW),
        .p_flags_width(FW),
        .p_words      (NW)
    ) dut (
        .i_w_clk        (clk),
        .i_w_rst_n      (rst_n),
        .i_w_req_valid  (req_valid),
        .o_w_req_ready  (req_ready),
        .i_w_req_opcode (req_opcode),
        .i_w_req_op1    (req_op1),
        .i_w_req_op2    (req_op2),
        .i_w_req_carry  (req_carry),
        .o_w_rsp_valid  (rsp_valid),
        .i_w_rsp_ready  (rsp_ready),
        .o_w_rsp_result (rsp_result),
        .o_w_rsp_flags  (rsp_flags),
        .o_w_alu_op1    (alu_op1),
        .o_w_alu_op2    (alu_op2),
        .o_w_alu_opcode (alu_opcode),
        .o_w_alu_carry  (alu_carry),
        .o_w_alu_oe     (alu_oe),
        .i_w_alu_out    (alu_out),
        .i_w_alu_flags  (alu_flags)
    );

    // Behavioural single-word ALU: flags {P,S,Z,O,C}, borrow reported as C
    // for subtraction, unsupported opcodes and oe=0 give all zeros.
    logic [DW:0]   alu_tmp;
    logic [DW-1:0] alu_r;
    logic          alu_c;
    logic          alu_o;
    logic          alu_sup;
    always_comb begin
        alu_tmp   = '0;
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_o     = 1'b0;
        alu_sup   = 1'b1;
        alu_out   = '0;
        alu_flags = '0;
        case (alu_opcode)
            4'd0: begin
                alu_tmp = {1'b0, alu_op1} + {1'b0, alu_op2} + {{DW{1'b0}}, alu_carry};
                alu_r   = alu_tmp[DW-1:0];
                alu_c   = alu_tmp[DW];
                alu_o   = (alu_op1[DW-1] == alu_op2[DW-1]) && (alu_r[DW-1] != alu_op1[DW-1]);
            end
            4'd1: begin
                alu_tmp = {1'b0, alu_op1} - {1'b0, alu_op2} - {{DW{1'b0}}, alu_carry};
                alu_r   = alu_tmp[DW-1:0];
                alu_c   = alu_tmp[DW];
                alu_o   = (alu_op1[DW-1] != alu_op2[DW-1]) && (alu_r[DW-1] != alu_op1[DW-1]);
            end
            4'd2: begin
                alu_tmp = {1'b0, alu_op2} - {1'b0, alu_op1} - {{DW{1'b0}}, alu_carry};
                alu_r   = alu_tmp[DW-1:0];
                alu_c   = alu_tmp[DW];
                alu_o   = (alu_op2[DW-1] != alu_op1[DW-1]) && (alu_r[DW-1] != alu_op2[DW-1]);
            end
            4'd3: alu_r = ~(alu_op1 | alu_op2);
            4'd4: alu_r = alu_op1 & alu_op2;
            4'd5: alu_r = alu_op1 | alu_op2;
            4'd6: alu_r = alu_op1 ^ alu_op2;
            4'd7: begin
                alu_r = {alu_op1[DW-2:0], 1'b0};
                alu_c = alu_op1[DW-1];
            end
            4'd8: begin
                alu_r = {1'b0, alu_op1[DW-1:1]};
                alu_c = alu_op1[0];
            end
            4'd9: begin
                alu_r = {alu_op1[DW-1], alu_op1[DW-1:1]};
                alu_c = alu_op1[0];
            end
            default: alu_sup = 1'b0;
        endcase
        if (alu_oe && alu_sup) begin
            alu_out   = alu_r;
            alu_flags = {~^alu_r, alu_r[DW-1], (alu_r == '0), alu_o, alu_c};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Issue one request from a negedge, record the per-step ALU drive and wait
    // (bounded) for rsp_valid. Returns at a negedge with the response pending.
    task automatic applyStimulus(input logic [3:0] op, input logic [WW-1:0] a,
                                 input logic [WW-1:0] b, input logic cin);
        req_opcode = op;
        req_op1    = a;
        req_op2    = b;
        req_carry  = cin;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (lat < NW) begin
                step_opcode[lat] = alu_opcode;
                step_carry[lat]  = alu_carry;
                step_cout[lat]   = alu_flags[0];
                step_oe[lat]     = alu_oe;
                step_op1[lat]    = alu_op1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("latency", lat, 32'd3);
    endtask

    task automatic releaseResponse();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_carry  = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_result", rsp_result, 32'd0);
        checkOutput("rst_flags", 32'(rsp_flags), 32'd0);
        checkOutput("rst_alu_oe", 32'(alu_oe), 32'd0);
        checkOutput("rst_alu_op1", 32'(alu_op1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        $display("[TB] ADC carry across word boundary");
        applyStimulus(4'd0, 32'h0000FFFF, 32'h00000001, 1'b0);
        checkOutput("adc1_result", rsp_result, 32'h00010000);
        checkOutput("adc1_flags", 32'(rsp_flags), 32'h10);
        checkOutput("adc1_oe0", 32'(step_oe[0]), 32'd1);
        checkOutput("adc1_op1_w0", 32'(step_op1[0]), 32'hFFFF);
        checkOutput("adc1_op1_w1", 32'(step_op1[1]), 32'h0000);
        checkOutput("adc1_carry1", 32'(step_carry[1]), 32'd1);
        releaseResponse();

        $display("[TB] ADC wrap to zero");
        applyStimulus(4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        checkOutput("adc2_result", rsp_result, 32'h00000000);
        checkOutput("adc2_flags", 32'(rsp_flags), 32'h15);
        releaseResponse();

        $display("[TB] SBB1 borrow across word boundary");
        applyStimulus(4'd1, 32'h00010000, 32'h00000001, 1'b0);
        checkOutput("sbb_result", rsp_result, 32'h0000FFFF);
        checkOutput("sbb_flags", 32'(rsp_flags), 32'h10);
        checkOutput("sbb_cout0", 32'(step_cout[0]), 32'd1);
        checkOutput("sbb_carry1", 32'(step_carry[1]), 32'd1);
        releaseResponse();

        $display("[TB] SHL across word boundary");
        applyStimulus(4'd7, 32'h00008000, 32'hFFFFFFFF, 1'b1);
        checkOutput("shl_result", rsp_result, 32'h00010000);
        checkOutput("shl_flags", 32'(rsp_flags), 32'h10);
        checkOutput("shl_carry0", 32'(step_carry[0]), 32'd0);
        releaseResponse();

        $display("[TB] SAR with sign fill");
        applyStimulus(4'd9, 32'h80000001, 32'h00000000, 1'b0);
        checkOutput("sar_result", rsp_result, 32'hC0000000);
        checkOutput("sar_flags", 32'(rsp_flags), 32'h19);
        checkOutput("sar_opc0", 32'(step_opcode[0]), 32'd9);
        checkOutput("sar_opc1", 32'(step_opcode[1]), 32'd8);
        checkOutput("sar_op1_w1", 32'(step_op1[0]), 32'h8000);
        releaseResponse();

        $display("[TB] SHR bit injected into lower word");
        applyStimulus(4'd8, 32'h00010000, 32'h00000000, 1'b0);
        checkOutput("shr_result", rsp_result, 32'h00008000);
        checkOutput("shr_flags", 32'(rsp_flags), 32'h00);
        releaseResponse();

        $display("[TB] XOR");
        applyStimulus(4'd6, 32'h1234ABCD, 32'hFFFF0000, 1'b1);
        checkOutput("xor_result", rsp_result, 32'hEDCBABCD);
        checkOutput("xor_flags", 32'(rsp_flags), 32'h18);
        checkOutput("xor_carry0", 32'(step_carry[0]), 32'd0);
        releaseResponse();

        $display("[TB] unsupported opcode");
        applyStimulus(4'd12, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        checkOutput("unsup_result", rsp_result, 32'h00000000);
        checkOutput("unsup_flags", 32'(rsp_flags), 32'h14);
        releaseResponse();

        $display("[TB] response backpressure");
        applyStimulus(4'd0, 32'h12345678, 32'h11111111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req_valid  = 1'b1;
            req_opcode = 4'd4;
            req_op1    = 32'hDEADBEEF;
            req_op2    = 32'h0F0F0F0F;
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_result", rsp_result, 32'h23456789);
            checkOutput("hold_flags", 32'(rsp_flags), 32'h10);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_alu_oe", 32'(alu_oe), 32'd0);
        end
        req_valid = 1'b0;
        releaseResponse();
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_no_accept", 32'(alu_oe), 32'd0);

        $display("[TB] reset during RUN");
        req_opcode = 4'd0;
        req_op1    = 32'h0000FFFF;
        req_op2    = 32'h00000001;
        req_carry  = 1'b0;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("run_step1_oe", 32'(alu_oe), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_alu_oe", 32'(alu_oe), 32'd0);
        checkOutput("abort_alu_op1", 32'(alu_op1), 32'd0);
        checkOutput("abort_alu_carry", 32'(alu_carry), 32'd0);
        checkOutput("abort_result", rsp_result, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_discarded", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
